fetch_unit: RTL

//   Instruction-fetch stage feeding the asynchronous instruction memory.
//   - Owns the program counter; drives the word-aligned fetch address to the memory.
//   - Captures the returned instruction into an IF/ID pipeline register for the decoder.
//   - Supports stall (hold), redirect (branch/jump, flushes IF/ID) and a saturating fetch counter.

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_unit.sv | 93 +++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: control in, fetch address out, instruction back, IF/ID register out.
// master = fetch unit side, slave = memory/decoder/control side.
interface fetch_if #(
  parameter int unsigned COUNT_W = 16
) ();
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_target;
  logic [31:0]        endereco;
  logic [31:0]        instrucao;
  logic               if_id_valid;
  logic [31:0]        if_id_instrucao;
  logic [31:0]        if_id_pc;
  logic [31:0]        if_id_pc_mais4;
  logic [COUNT_W-1:0] fetch_count;
  logic               fault;

  modport master (
    input  stall, redirect, redirect_target, instrucao,
    output endereco, if_id_valid, if_id_instrucao, if_id_pc, if_id_pc_mais4, fetch_count, fault
  );

  modport slave (
    output stall, redirect, redirect_target, instrucao,
    input  endereco, if_id_valid, if_id_instrucao, if_id_pc, if_id_pc_mais4, fetch_count, fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID register, saturating fetch counter.
// Define FETCH_BOUNDS_CHECK_EN to halt with a sticky fault on out-of-range fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 13,
  parameter int unsigned COUNT_W   = 16  // must match the interface's COUNT_W
) (
  input logic      clk,
  input logic      reset,
  fetch_if.master  bus
);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        ipc_q, ipc_d;
  logic [31:0]        pc4_q, pc4_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               fault_q, fault_d;
  logic               out_of_range;

  assign out_of_range = {2'b00, pc_q[31:2]} >= MEM_WORDS;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    pc4_d   = pc4_q;
    count_d = count_q;
    fault_d = fault_q;
    if (state_q == StRun) begin
      if (bus.redirect) begin
        pc_d    = bus.redirect_target & 32'hFFFF_FFFC;
        valid_d = 1'b0;
      end else if (bus.stall) begin
        // hold everything
      end else if (BoundsEn && out_of_range) begin
        valid_d = 1'b0;
        fault_d = 1'b1;
        state_d = StHalt;
      end else begin
        instr_d = bus.instrucao;
        ipc_d   = pc_q;
        pc4_d   = pc_q + 32'd4;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
        if (count_q != {COUNT_W{1'b1}}) count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
      pc4_q   <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      pc4_q   <= pc4_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  assign bus.endereco        = pc_q;
  assign bus.if_id_valid     = valid_q;
  assign bus.if_id_instrucao = instr_q;
  assign bus.if_id_pc        = ipc_q;
  assign bus.if_id_pc_mais4  = pc4_q;
  assign bus.fetch_count     = count_q;
  assign bus.fault           = BoundsEn ? fault_q : 1'b0;

endmodule
